branch_resolve_queue: RTL

//  In-order queue of in-flight predicted branches between PC/fetch and the gshare predictor update port.

---
 rtl/branch_resolve_queue_pkg.sv | 36 +++
 rtl/branch_resolve_queue_stat_counter.sv | 19 +
 rtl/branch_resolve_queue.sv | 134 +++++++++++++
 3 files changed

// File: rtl/branch_resolve_queue_pkg.sv
// Shared widths and entry payload type for the branch resolve queue.
// Also provides the legacy defines `indexWidth, `addrWidth, `brqTagWidth, `brqDepth.
`ifndef indexWidth
`define indexWidth 6
`endif
`ifndef addrWidth
`define addrWidth 17
`endif
`ifndef brqTagWidth
`define brqTagWidth 3
`endif
`ifndef brqDepth
`define brqDepth 8
`endif

package branch_resolve_queue_pkg;

    localparam int BRQ_DEPTH  = `brqDepth;
    localparam int BRQ_TAG_W  = `brqTagWidth;
    localparam int BRQ_IDX_W  = `indexWidth;
    localparam int BRQ_ADDR_W = `addrWidth;
    localparam int BRQ_STAT_W = 32;

    typedef struct packed {
        logic                  pred;
        logic                  taken;
        logic [BRQ_IDX_W-1:0]  idx;
        logic [BRQ_ADDR_W-1:0] target;
    } brq_payload_t;

    // Pointers are exactly TAG_W bits wide, so the natural overflow is the modulo-DEPTH wrap.
    function automatic logic [BRQ_TAG_W-1:0] brq_ptr_inc(input logic [BRQ_TAG_W-1:0] ptr);
        return ptr + 1'b1;
    endfunction

endpackage

// File: rtl/branch_resolve_queue_stat_counter.sv
// Saturating increment-enable event counter used for the optional retire/mispredict statistics.
module brq_stat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/branch_resolve_queue.sv
// In-order queue of predicted branches: out-of-order resolve by tag, in-order retire to the predictor.
// Define BRQ_STATS_EN to build the stat_retired / stat_mispred counters; otherwise they read zero.
module branch_resolve_queue
    import branch_resolve_queue_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rdy,
    input  logic                  alloc_en,
    input  logic [BRQ_IDX_W-1:0]  alloc_idx,
    input  logic                  alloc_pred,
    output logic [BRQ_TAG_W-1:0]  alloc_tag,
    output logic                  full,
    input  logic                  resolve_en,
    input  logic [BRQ_TAG_W-1:0]  resolve_tag,
    input  logic                  resolve_taken,
    input  logic [BRQ_ADDR_W-1:0] resolve_target,
    output logic                  modify_en,
    output logic [BRQ_IDX_W-1:0]  modify_PC,
    output logic                  choice,
    output logic                  clear,
    output logic                  redirect_en,
    output logic [BRQ_ADDR_W-1:0] redirect_pc,
    output logic [BRQ_STAT_W-1:0] stat_retired,
    output logic [BRQ_STAT_W-1:0] stat_mispred
);

    localparam logic [BRQ_TAG_W:0] FULL_COUNT = (BRQ_TAG_W+1)'(BRQ_DEPTH);

    logic [BRQ_DEPTH-1:0] valid_q;
    logic [BRQ_DEPTH-1:0] resolved_q;
    brq_payload_t         payload_q [BRQ_DEPTH];
    logic [BRQ_TAG_W-1:0] head_q;
    logic [BRQ_TAG_W-1:0] tail_q;
    logic [BRQ_TAG_W:0]   count_q;

    brq_payload_t head_ent;
    logic         retire_fire;
    logic         retire_mispred;
    logic         alloc_fire;
    logic         resolve_fire;

    assign alloc_tag = tail_q;
    assign full      = (count_q == FULL_COUNT);

    assign head_ent       = payload_q[head_q];
    assign retire_fire    = valid_q[head_q] & resolved_q[head_q];
    assign retire_mispred = retire_fire & (head_ent.taken != head_ent.pred);

    // Acceptance: alloc_en is taken only when not full and no flush is in progress or being
    // registered (fetch holds the branch otherwise); resolve_en is fire-and-forget and is
    // silently dropped for dead, already-resolved or flushed entries.
    assign alloc_fire   = alloc_en & ~full & ~clear & ~retire_mispred;
    assign resolve_fire = resolve_en & valid_q[resolve_tag] & ~resolved_q[resolve_tag]
                        & ~retire_mispred;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= '0;
            resolved_q  <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            modify_en   <= 1'b0;
            modify_PC   <= '0;
            choice      <= 1'b0;
            clear       <= 1'b0;
            redirect_en <= 1'b0;
            redirect_pc <= '0;
            for (int i = 0; i < BRQ_DEPTH; i++) begin
                payload_q[i] <= '0;
            end
        end else if (rdy) begin
            modify_en   <= retire_fire;
            modify_PC   <= retire_fire ? head_ent.idx : '0;
            choice      <= retire_fire & head_ent.taken;
            clear       <= retire_mispred;
            redirect_en <= retire_mispred;
            redirect_pc <= retire_mispred ? head_ent.target : '0;

            if (retire_mispred) begin
                // Everything younger than the mispredicted branch is on the wrong path.
                valid_q    <= '0;
                resolved_q <= '0;
                head_q     <= '0;
                tail_q     <= '0;
                count_q    <= '0;
            end else begin
                if (retire_fire) begin
                    valid_q[head_q]    <= 1'b0;
                    resolved_q[head_q] <= 1'b0;
                    head_q             <= brq_ptr_inc(head_q);
                end
                if (alloc_fire) begin
                    valid_q[tail_q]        <= 1'b1;
                    resolved_q[tail_q]     <= 1'b0;
                    payload_q[tail_q].pred <= alloc_pred;
                    payload_q[tail_q].idx  <= alloc_idx;
                    tail_q                 <= brq_ptr_inc(tail_q);
                end
                if (resolve_fire) begin
                    resolved_q[resolve_tag]       <= 1'b1;
                    payload_q[resolve_tag].taken  <= resolve_taken;
                    payload_q[resolve_tag].target <= resolve_target;
                end
                case ({alloc_fire, retire_fire})
                    2'b10:   count_q <= count_q + 1'b1;
                    2'b01:   count_q <= count_q - 1'b1;
                    default: count_q <= count_q;
                endcase
            end
        end
    end

`ifdef BRQ_STATS_EN
    brq_stat_counter #(.W(BRQ_STAT_W)) u_stat_retired (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (rdy & retire_fire),
        .count (stat_retired)
    );

    brq_stat_counter #(.W(BRQ_STAT_W)) u_stat_mispred (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (rdy & retire_mispred),
        .count (stat_mispred)
    );
`else
    assign stat_retired = '0;
    assign stat_mispred = '0;
`endif

endmodule
